ika9958_regwr_ctrl: RTL and testbench

// - CPU-port write sequencer for the IKA9958 register file and palette.
// - Decodes V9958 port #1/#2/#3 byte sequences into single-cycle write strobes for the register file (R#0..R#NREG-1) and the palette RAM.
// - Also emits VRAM address-setup strobes.
// - Holds the byte-phase flags and the R#17/R#16 auto-increment pointers; the register storage itself lives downstream.

---
 rtl/ika9958_regwr_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_ika9958_regwr_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ika9958_regwr_ctrl.sv
// CPU port #1/#2/#3 write sequencer for the IKA9958 register file and palette.
// Palette sequencing on port #2 is built only with IKA9958_REGWR_PALETTE_EN.
module ika9958_regwr_ctrl #(
    parameter int NREG = 47
) (
    input  logic        i_EMUCLK,
    input  logic        i_RST_n,
    input  logic        i_cpu_wr,
    input  logic        i_cpu_rd,
    input  logic [1:0]  i_cpu_port,
    input  logic [7:0]  i_cpu_data,
    output logic        o_reg_we,
    output logic [5:0]  o_reg_addr,
    output logic [7:0]  o_reg_data,
    output logic        o_vaddr_we,
    output logic [13:0] o_vaddr,
    output logic        o_vaddr_wr,
    output logic        o_pal_we,
    output logic [3:0]  o_pal_idx,
    output logic [8:0]  o_pal_data
);

    localparam logic [6:0] NREG_W = 7'(NREG);

    logic        p1_phase_q, p1_phase_d;
    logic [7:0]  lat1_q, lat1_d;
    logic [5:0]  ptr17_q, ptr17_d;
    logic        aii_q, aii_d;
    logic        reg_we_q, reg_we_d;
    logic [5:0]  reg_addr_q, reg_addr_d;
    logic [7:0]  reg_data_q, reg_data_d;
    logic        vaddr_we_q, vaddr_we_d;
    logic [13:0] vaddr_q, vaddr_d;
    logic        vaddr_wr_q, vaddr_wr_d;

    logic        rw_hit;
    logic [5:0]  rw_addr;
    logic [7:0]  rw_data;

`ifdef IKA9958_REGWR_PALETTE_EN
    logic        p2_phase_q, p2_phase_d;
    logic [7:0]  lat2_q, lat2_d;
    logic [3:0]  ptr16_q, ptr16_d;
    logic        pal_we_q, pal_we_d;
    logic [3:0]  pal_idx_q, pal_idx_d;
    logic [8:0]  pal_data_q, pal_data_d;
`endif

    always_comb begin
        p1_phase_d = p1_phase_q;
        lat1_d     = lat1_q;
        ptr17_d    = ptr17_q;
        aii_d      = aii_q;
        reg_we_d   = 1'b0;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        vaddr_we_d = 1'b0;
        vaddr_d    = vaddr_q;
        vaddr_wr_d = vaddr_wr_q;
        rw_hit     = 1'b0;
        rw_addr    = 6'd0;
        rw_data    = 8'd0;
`ifdef IKA9958_REGWR_PALETTE_EN
        p2_phase_d = p2_phase_q;
        lat2_d     = lat2_q;
        ptr16_d    = ptr16_q;
        pal_we_d   = 1'b0;
        pal_idx_d  = pal_idx_q;
        pal_data_d = pal_data_q;
`endif
        // A write wins over a simultaneous read.
        if (i_cpu_wr) begin
            unique case (i_cpu_port)
                2'd0: p1_phase_d = 1'b0;
                2'd1: begin
                    if (!p1_phase_q) begin
                        lat1_d     = i_cpu_data;
                        p1_phase_d = 1'b1;
                    end else begin
                        p1_phase_d = 1'b0;
                        if (i_cpu_data[7]) begin
                            rw_hit  = 1'b1;
                            rw_addr = i_cpu_data[5:0];
                            rw_data = lat1_q;
                            if (i_cpu_data[5:0] == 6'd17) begin
                                ptr17_d = lat1_q[5:0];
                                aii_d   = lat1_q[7];
                            end
                        end else begin
                            vaddr_we_d = 1'b1;
                            vaddr_d    = {i_cpu_data[5:0], lat1_q};
                            vaddr_wr_d = i_cpu_data[6];
                        end
                    end
                end
                2'd2: begin
`ifdef IKA9958_REGWR_PALETTE_EN
                    if (!p2_phase_q) begin
                        lat2_d     = i_cpu_data;
                        p2_phase_d = 1'b1;
                    end else begin
                        p2_phase_d = 1'b0;
                        pal_we_d   = 1'b1;
                        pal_idx_d  = ptr16_q;
                        pal_data_d = {lat2_q[6:4], lat2_q[2:0],
                                      i_cpu_data[2:0]};
                        ptr16_d    = ptr16_q + 4'd1;
                    end
`endif
                end
                2'd3: begin
                    // R#17 never writes itself through the indirect port.
                    if (ptr17_q != 6'd17) begin
                        rw_hit  = 1'b1;
                        rw_addr = ptr17_q;
                        rw_data = i_cpu_data;
                    end
                    if (!aii_q) ptr17_d = ptr17_q + 6'd1;
                end
            endcase
        end else if (i_cpu_rd) begin
            if (i_cpu_port == 2'd0 || i_cpu_port == 2'd1)
                p1_phase_d = 1'b0;
        end

        if (rw_hit) begin
            if ({1'b0, rw_addr} < NREG_W) begin
                reg_we_d   = 1'b1;
                reg_addr_d = rw_addr;
                reg_data_d = rw_data;
            end
`ifdef IKA9958_REGWR_PALETTE_EN
            if (rw_addr == 6'd16) begin
                ptr16_d    = rw_data[3:0];
                p2_phase_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (!i_RST_n) begin
            p1_phase_q <= 1'b0;
            lat1_q     <= 8'd0;
            ptr17_q    <= 6'd0;
            aii_q      <= 1'b0;
            reg_we_q   <= 1'b0;
            reg_addr_q <= 6'd0;
            reg_data_q <= 8'd0;
            vaddr_we_q <= 1'b0;
            vaddr_q    <= 14'd0;
            vaddr_wr_q <= 1'b0;
`ifdef IKA9958_REGWR_PALETTE_EN
            p2_phase_q <= 1'b0;
            lat2_q     <= 8'd0;
            ptr16_q    <= 4'd0;
            pal_we_q   <= 1'b0;
            pal_idx_q  <= 4'd0;
            pal_data_q <= 9'd0;
`endif
        end else begin
            p1_phase_q <= p1_phase_d;
            lat1_q     <= lat1_d;
            ptr17_q    <= ptr17_d;
            aii_q      <= aii_d;
            reg_we_q   <= reg_we_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            vaddr_we_q <= vaddr_we_d;
            vaddr_q    <= vaddr_d;
            vaddr_wr_q <= vaddr_wr_d;
`ifdef IKA9958_REGWR_PALETTE_EN
            p2_phase_q <= p2_phase_d;
            lat2_q     <= lat2_d;
            ptr16_q    <= ptr16_d;
            pal_we_q   <= pal_we_d;
            pal_idx_q  <= pal_idx_d;
            pal_data_q <= pal_data_d;
`endif
        end
    end

    assign o_reg_we   = reg_we_q;
    assign o_reg_addr = reg_addr_q;
    assign o_reg_data = reg_data_q;
    assign o_vaddr_we = vaddr_we_q;
    assign o_vaddr    = vaddr_q;
    assign o_vaddr_wr = vaddr_wr_q;
`ifdef IKA9958_REGWR_PALETTE_EN
    assign o_pal_we   = pal_we_q;
    assign o_pal_idx  = pal_idx_q;
    assign o_pal_data = pal_data_q;
`else
    assign o_pal_we   = 1'b0;
    assign o_pal_idx  = 4'd0;
    assign o_pal_data = 9'd0;
`endif

endmodule

// File: tb/tb_ika9958_regwr_ctrl.sv
// Directed bench for ika9958_regwr_ctrl; palette steps follow
// IKA9958_REGWR_PALETTE_EN.
module tb_ika9958_regwr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_wr = 1'b0;
    logic        cpu_rd = 1'b0;
    logic [1:0]  cpu_port = 2'd0;
    logic [7:0]  cpu_data = 8'd0;
    logic        reg_we;
    logic [5:0]  reg_addr;
    logic [7:0]  reg_data;
    logic        vaddr_we;
    logic [13:0] vaddr;
    logic        vaddr_wr;
    logic        pal_we;
    logic [3:0]  pal_idx;
    logic [8:0]  pal_data;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ika9958_regwr_ctrl dut (
        .i_EMUCLK   (clk),
        .i_RST_n    (rst_n),
        .i_cpu_wr   (cpu_wr),
        .i_cpu_rd   (cpu_rd),
        .i_cpu_port (cpu_port),
        .i_cpu_data (cpu_data),
        .o_reg_we   (reg_we),
        .o_reg_addr (reg_addr),
        .o_reg_data (reg_data),
        .o_vaddr_we (vaddr_we),
        .o_vaddr    (vaddr),
        .o_vaddr_wr (vaddr_wr),
        .o_pal_we   (pal_we),
        .o_pal_idx  (pal_idx),
        .o_pal_data (pal_data)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Strobe for one cycle; returns on the negedge after the capturing edge.
    task automatic cyc(input logic w, input logic r, input logic [1:0] p,
                       input logic [7:0] d);
        @(negedge clk);
        cpu_wr = w; cpu_rd = r; cpu_port = p; cpu_data = d;
        @(negedge clk);
        cpu_wr = 1'b0; cpu_rd = 1'b0;
    endtask

    task automatic wr(input logic [1:0] p, input logic [7:0] d);
        cyc(1'b1, 1'b0, p, d);
    endtask

    task automatic rd(input logic [1:0] p);
        cyc(1'b0, 1'b1, p, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_reg(input string tag, input logic [5:0] a,
                           input logic [7:0] d);
        chk({tag, ".we"}, 16'(reg_we), 16'd1);
        chk({tag, ".addr"}, 16'(reg_addr), 16'(a));
        chk({tag, ".data"}, 16'(reg_data), 16'(d));
    endtask

    task automatic chk_none(input string tag);
        chk({tag, ".reg_we"}, 16'(reg_we), 16'd0);
        chk({tag, ".vaddr_we"}, 16'(vaddr_we), 16'd0);
        chk({tag, ".pal_we"}, 16'(pal_we), 16'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_none("rst");
        chk("rst.reg_addr", 16'(reg_addr), 16'd0);
        chk("rst.reg_data", 16'(reg_data), 16'd0);
        chk("rst.vaddr", 16'(vaddr), 16'd0);
        chk("rst.vaddr_wr", 16'(vaddr_wr), 16'd0);
        chk("rst.pal_idx", 16'(pal_idx), 16'd0);
        chk("rst.pal_data", 16'(pal_data), 16'd0);

        wr(1, 8'h01);
        chk_none("p1.first");
        wr(1, 8'h80);
        chk_reg("p1.r0", 6'd0, 8'h01);
        chk("p1.r0.vaddr_we", 16'(vaddr_we), 16'd0);
        @(negedge clk);
        chk("p1.pulse_one_cycle", 16'(reg_we), 16'd0);

        wr(1, 8'h34);
        chk_none("va.first");
        wr(1, 8'h52);
        chk("va.we", 16'(vaddr_we), 16'd1);
        chk("va.addr", 16'(vaddr), 16'h1234);
        chk("va.wr", 16'(vaddr_wr), 16'd1);
        chk("va.reg_we", 16'(reg_we), 16'd0);
        chk("va.hold_addr", 16'(reg_addr), 16'd0);
        chk("va.hold_data", 16'(reg_data), 16'h01);

        wr(1, 8'hAA);
        rd(1);
        wr(1, 8'h87);
        chk_none("rdrst.first");
        wr(1, 8'h91);
        chk_reg("rdrst.r17", 6'd17, 8'h87);

        wr(1, 8'h12);
        wr(0, 8'hFF);
        wr(1, 8'h40);
        chk_none("p0rst.first");
        wr(1, 8'h00);
        chk("p0rst.vaddr", 16'(vaddr), 16'h0040);
        chk("p0rst.vwr", 16'(vaddr_wr), 16'd0);
        chk("p0rst.vwe", 16'(vaddr_we), 16'd1);

        cyc(1'b1, 1'b1, 2'd1, 8'h22);
        chk_none("wrrd.first");
        wr(1, 8'h81);
        chk_reg("wrrd.r1", 6'd1, 8'h22);

        wr(1, 8'h0A);
        rd(2);
        rd(3);
        wr(1, 8'h82);
        chk_reg("rd23.r2", 6'd2, 8'h0A);

        wr(1, 8'h3E);
        wr(1, 8'h91);
        chk_reg("ind.r17", 6'd17, 8'h3E);
        wr(3, 8'h11);
        chk("ind.r62_drop", 16'(reg_we), 16'd0);
        wr(3, 8'h22);
        chk("ind.r63_drop", 16'(reg_we), 16'd0);
        wr(3, 8'h33);
        chk_reg("ind.r0", 6'd0, 8'h33);
        wr(3, 8'h44);
        chk_reg("ind.r1", 6'd1, 8'h44);

        wr(1, 8'h11);
        wr(1, 8'h91);
        wr(3, 8'h55);
        chk("self17.drop", 16'(reg_we), 16'd0);
        wr(3, 8'h66);
        chk_reg("self17.r18", 6'd18, 8'h66);

        wr(1, 8'h85);
        wr(1, 8'h91);
        wr(3, 8'hA1);
        chk_reg("aii.1", 6'd5, 8'hA1);
        wr(3, 8'hA2);
        chk_reg("aii.2", 6'd5, 8'hA2);
        wr(3, 8'hA3);
        chk_reg("aii.3", 6'd5, 8'hA3);

        wr(1, 8'h55);
        do_reset();
        chk_none("rst1.mid");
        chk("rst1.reg_addr", 16'(reg_addr), 16'd0);
        wr(1, 8'h81);
        chk_none("rst1.first");
        wr(1, 8'h83);
        chk_reg("rst1.r3", 6'd3, 8'h81);

        wr(1, 8'h0F);
        wr(1, 8'h90);
        chk_reg("r16", 6'd16, 8'h0F);
`ifdef IKA9958_REGWR_PALETTE_EN
        wr(2, 8'h70);
        chk_none("pal.first");
        wr(2, 8'h07);
        chk("pal.we", 16'(pal_we), 16'd1);
        chk("pal.idx", 16'(pal_idx), 16'd15);
        chk("pal.data", 16'(pal_data), 16'h1C7);
        wr(2, 8'h12);
        wr(2, 8'h05);
        chk("pal.wrap_idx", 16'(pal_idx), 16'd0);
        chk("pal.wrap_data", 16'(pal_data), 16'h055);

        wr(2, 8'h33);
        wr(1, 8'h03);
        wr(1, 8'h90);
        chk_reg("pal.r16b", 6'd16, 8'h03);
        wr(2, 8'h44);
        chk_none("pal.phrst");
        wr(2, 8'h06);
        chk("pal.phrst_we", 16'(pal_we), 16'd1);
        chk("pal.phrst_idx", 16'(pal_idx), 16'd3);
        chk("pal.phrst_data", 16'(pal_data), 16'h126);

        wr(2, 8'h77);
        do_reset();
        chk_none("pal.rst");
        wr(2, 8'h01);
        chk_none("pal.rst_first");
        wr(2, 8'h02);
        chk("pal.rst_we", 16'(pal_we), 16'd1);
        chk("pal.rst_idx", 16'(pal_idx), 16'd0);
        chk("pal.rst_data", 16'(pal_data), 16'h00A);
`else
        wr(2, 8'h70);
        chk_none("nopal.first");
        wr(2, 8'h07);
        chk_none("nopal.second");
        chk("nopal.idx", 16'(pal_idx), 16'd0);
        chk("nopal.data", 16'(pal_data), 16'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
